// File: rtl/sprite_frame_scheduler.sv
// Double-buffered sprite frame loader: CPU fills a shadow bank, a posted commit
// is copied into the visibility checker on the next vblank rising edge.
module sprite_frame_scheduler #(
    parameter int SPRITE_COUNT = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_cpu_write,
    input  logic [7:0]  i_cpu_address,
    input  logic [31:0] i_cpu_writedata,
    output logic        o_cpu_waitrequest,
    input  logic        i_vblank,
    output logic        o_chk_write,
    output logic [7:0]  o_chk_address,
    output logic [31:0] o_chk_writedata,
    output logic        o_busy,
    output logic        o_commit_pending,
    output logic        o_frame_done,
    output logic [15:0] o_frame_count,
    output logic        o_overrun
);

    localparam int          SHADOW_WORDS = SPRITE_COUNT + 3;
    localparam int          IDX_W        = $clog2(SHADOW_WORDS);
    localparam logic [7:0]  LAST_IDX     = 8'(SHADOW_WORDS - 1);
    localparam logic [7:0]  COMMIT_ADDR  = 8'(SHADOW_WORDS);
    localparam logic [7:0]  CLEAR_ADDR   = 8'(SHADOW_WORDS + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_COPY, ST_COMMIT, ST_DONE} state_t;

    state_t      r_state;
    logic [7:0]  r_idx;
    logic [31:0] r_shadow [SHADOW_WORDS];
    logic        r_vblank_d;
    logic        r_commit_pending;
    logic        r_overrun;
    logic        r_chk_write;
    logic [7:0]  r_chk_address;
    logic [31:0] r_chk_writedata;
    logic        r_frame_done;
    logic [15:0] r_frame_count;

    logic        w_busy;
    logic        w_accept;
    logic        w_commit;
    logic        w_clear;
    logic        w_vb_rise;
    logic        w_start;
    logic [7:0]  w_next_idx;

    assign w_busy     = (r_state == ST_COPY) || (r_state == ST_COMMIT);
    assign w_accept   = i_cpu_write && !w_busy;
    assign w_commit   = w_accept && (i_cpu_address == COMMIT_ADDR);
    assign w_clear    = w_accept && (i_cpu_address == CLEAR_ADDR);
    assign w_vb_rise  = i_vblank && !r_vblank_d;
    assign w_start    = (r_state == ST_IDLE) && w_vb_rise && r_commit_pending;
    assign w_next_idx = r_idx + 8'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SHADOW_WORDS; i++) r_shadow[i] <= '0;
        end else if (w_accept && (i_cpu_address < COMMIT_ADDR)) begin
            r_shadow[i_cpu_address[IDX_W-1:0]] <= i_cpu_writedata;
        end
    end

    // A commit landing in the same cycle as the starting edge is kept for the next edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vblank_d       <= 1'b0;
            r_commit_pending <= 1'b0;
            r_overrun        <= 1'b0;
        end else begin
            r_vblank_d <= i_vblank;
            if (w_start)
                r_commit_pending <= w_commit;
            else if (w_commit)
                r_commit_pending <= 1'b1;
            if (w_clear)
                r_overrun <= 1'b0;
            else if (w_commit && r_commit_pending)
                r_overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= ST_IDLE;
            r_idx           <= '0;
            r_chk_write     <= 1'b0;
            r_chk_address   <= '0;
            r_chk_writedata <= '0;
            r_frame_done    <= 1'b0;
            r_frame_count   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state         <= ST_COPY;
                        r_idx           <= '0;
                        r_chk_write     <= 1'b1;
                        r_chk_address   <= '0;
                        r_chk_writedata <= r_shadow[0];
                    end
                end
                ST_COPY: begin
                    if (r_idx == LAST_IDX) begin
                        r_state         <= ST_COMMIT;
                        r_chk_address   <= COMMIT_ADDR;
                        r_chk_writedata <= '0;
                    end else begin
                        r_idx           <= w_next_idx;
                        r_chk_address   <= w_next_idx;
                        r_chk_writedata <= r_shadow[w_next_idx[IDX_W-1:0]];
                    end
                end
                ST_COMMIT: begin
                    r_state         <= ST_DONE;
                    r_chk_write     <= 1'b0;
                    r_chk_address   <= '0;
                    r_chk_writedata <= '0;
                    r_frame_done    <= 1'b1;
                    r_frame_count   <= r_frame_count + 16'd1;
                end
                ST_DONE: begin
                    r_state      <= ST_IDLE;
                    r_frame_done <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_cpu_waitrequest = w_busy;
    assign o_busy            = w_busy;
    assign o_chk_write       = r_chk_write;
    assign o_chk_address     = r_chk_address;
    assign o_chk_writedata   = r_chk_writedata;
    assign o_commit_pending  = r_commit_pending;
    assign o_frame_done      = r_frame_done;
    assign o_frame_count     = r_frame_count;
    assign o_overrun         = r_overrun;

endmodule

// File: tb/tb_sprite_frame_scheduler.sv
// Directed bench for sprite_frame_scheduler: transfer timing, stalls, overrun,
// mid-copy vblank drop, mid-transfer reset and frame counter wrap.
module tb_sprite_frame_scheduler;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_write;
    logic [7:0]  cpu_address;
    logic [31:0] cpu_writedata;
    logic        cpu_waitrequest;
    logic        vblank;
    logic        chk_write;
    logic [7:0]  chk_address;
    logic [31:0] chk_writedata;
    logic        busy;
    logic        commit_pending;
    logic        frame_done;
    logic [15:0] frame_count;
    logic        overrun;

    int n_cmp = 0;
    int n_bad = 0;

    int          x_nwr, x_first, x_done, x_busy, x_wait, x_order;
    logic [31:0] x_d3, x_d5, x_d35;
    int          n_stray;

    always #5 clk = ~clk;

    sprite_frame_scheduler #(.SPRITE_COUNT(32)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .i_cpu_write       (cpu_write),
        .i_cpu_address     (cpu_address),
        .i_cpu_writedata   (cpu_writedata),
        .o_cpu_waitrequest (cpu_waitrequest),
        .i_vblank          (vblank),
        .o_chk_write       (chk_write),
        .o_chk_address     (chk_address),
        .o_chk_writedata   (chk_writedata),
        .o_busy            (busy),
        .o_commit_pending  (commit_pending),
        .o_frame_done      (frame_done),
        .o_frame_count     (frame_count),
        .o_overrun         (overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_wr(input logic [7:0] addr, input logic [31:0] data);
        cpu_write     = 1'b1;
        cpu_address   = addr;
        cpu_writedata = data;
        tick();
        cpu_write     = 1'b0;
    endtask

    // Entered in cycle N (vblank just raised); observes cycles N+1..N+45.
    task automatic xfer(input int drop_at, input int wr_at, input logic [31:0] wr_data);
        bit acc;
        x_nwr = 0; x_first = 0; x_done = 0; x_busy = 0; x_wait = 0; x_order = 1;
        x_d3 = 32'hDEAD_DEAD; x_d5 = 32'hDEAD_DEAD; x_d35 = 32'hDEAD_DEAD;
        for (int i = 1; i <= 45; i++) begin
            acc = cpu_write && !cpu_waitrequest;
            tick();
            if (acc) cpu_write = 1'b0;
            if (drop_at == i) vblank = 1'b0;
            if (wr_at == i) begin
                cpu_write = 1'b1; cpu_address = 8'd3; cpu_writedata = wr_data;
            end
            if (cpu_write && cpu_waitrequest) x_wait++;
            if (busy) x_busy++;
            if (chk_write) begin
                if (x_nwr == 0) x_first = i;
                if (int'(chk_address) != x_nwr) x_order = 0;
                if (chk_address == 8'd3)  x_d3  = chk_writedata;
                if (chk_address == 8'd5)  x_d5  = chk_writedata;
                if (chk_address == 8'd35) x_d35 = chk_writedata;
                x_nwr++;
            end
            if (frame_done && x_done == 0) x_done = i;
        end
    endtask

    task automatic idle_cycles(input int n);
        n_stray = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (chk_write || busy) n_stray++;
        end
    endtask

    initial begin
        reset_n = 1'b0; cpu_write = 1'b0; cpu_address = '0; cpu_writedata = '0; vblank = 1'b0;
        tick(); tick();
        check("rst_waitrequest", 32'(cpu_waitrequest), 32'd0);
        check("rst_chk_write",   32'(chk_write), 32'd0);
        check("rst_chk_address", 32'(chk_address), 32'd0);
        check("rst_chk_data",    chk_writedata, 32'd0);
        check("rst_busy",        32'(busy), 32'd0);
        check("rst_pending",     32'(commit_pending), 32'd0);
        check("rst_frame_done",  32'(frame_done), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        check("rst_overrun",     32'(overrun), 32'd0);
        reset_n = 1'b1;
        tick();

        // Basic transfer
        cpu_wr(8'd5, 32'h00A0_1234);
        cpu_wr(8'd3, 32'h0000_0033);
        cpu_wr(8'd35, 32'hFFFF_FFFF);
        check("commit_pending_set", 32'(commit_pending), 32'd1);
        vblank = 1'b1;
        xfer(0, 0, 32'h0);
        check("t1_nwrites",    32'(x_nwr), 32'd36);
        check("t1_first_cyc",  32'(x_first), 32'd1);
        check("t1_order",      32'(x_order), 32'd1);
        check("t1_data5",      x_d5, 32'h00A0_1234);
        check("t1_data3",      x_d3, 32'h0000_0033);
        check("t1_data35",     x_d35, 32'd0);
        check("t1_busy_cyc",   32'(x_busy), 32'd36);
        check("t1_done_cyc",   32'(x_done), 32'd37);
        check("t1_frame_cnt",  32'(frame_count), 32'd1);
        check("t1_pending_clr", 32'(commit_pending), 32'd0);
        vblank = 1'b0; tick();

        // vblank edge with nothing pending
        vblank = 1'b1;
        idle_cycles(5);
        vblank = 1'b0; tick();
        check("nocommit_stray", 32'(n_stray), 32'd0);
        check("nocommit_count", 32'(frame_count), 32'd1);

        // Commit in the same cycle as the rising edge
        vblank = 1'b1; cpu_write = 1'b1; cpu_address = 8'd35; cpu_writedata = '0;
        tick();
        cpu_write = 1'b0;
        check("late_commit_pending", 32'(commit_pending), 32'd1);
        check("late_commit_busy",    32'(busy), 32'd0);
        idle_cycles(3);
        check("late_commit_stray",   32'(n_stray), 32'd0);
        vblank = 1'b0; tick();
        vblank = 1'b1;
        // Stalled write to address 3 issued at N+5
        xfer(0, 5, 32'h0000_BEEF);
        check("t2_nwrites",   32'(x_nwr), 32'd36);
        check("t2_old_data3", x_d3, 32'h0000_0033);
        check("t2_wait_cyc",  32'(x_wait), 32'd32);
        check("t2_wr_released", 32'(cpu_write), 32'd0);
        check("t2_frame_cnt", 32'(frame_count), 32'd2);
        vblank = 1'b0; tick();

        // Overrun
        cpu_wr(8'd35, 32'h0);
        cpu_wr(8'd35, 32'h0);
        check("overrun_set",     32'(overrun), 32'd1);
        check("overrun_pending", 32'(commit_pending), 32'd1);
        cpu_wr(8'd36, 32'h0);
        check("overrun_clr",     32'(overrun), 32'd0);
        vblank = 1'b1;
        xfer(0, 0, 32'h0);
        check("t3_nwrites",   32'(x_nwr), 32'd36);
        check("t3_new_data3", x_d3, 32'h0000_BEEF);
        vblank = 1'b0; tick();
        vblank = 1'b1;
        idle_cycles(5);
        check("t3_single_xfer", 32'(n_stray), 32'd0);
        check("t3_frame_cnt",   32'(frame_count), 32'd3);
        vblank = 1'b0; tick();

        // vblank falls mid-copy
        cpu_wr(8'd35, 32'h0);
        vblank = 1'b1;
        xfer(10, 0, 32'h0);
        check("drop_nwrites",  32'(x_nwr), 32'd36);
        check("drop_done_cyc", 32'(x_done), 32'd37);
        check("drop_frame_cnt", 32'(frame_count), 32'd4);
        tick();

        // Reset at N+10
        cpu_wr(8'd35, 32'h0);
        vblank = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("pre_reset_busy", 32'(busy), 32'd1);
        reset_n = 1'b0; vblank = 1'b0;
        #1;
        check("midrst_chk_write", 32'(chk_write), 32'd0);
        check("midrst_busy",      32'(busy), 32'd0);
        check("midrst_count",     32'(frame_count), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        cpu_wr(8'd35, 32'h0);
        vblank = 1'b1;
        xfer(0, 0, 32'h0);
        check("postrst_data5", x_d5, 32'd0);
        check("postrst_data3", x_d3, 32'd0);
        check("postrst_count", 32'(frame_count), 32'd1);
        vblank = 1'b0; tick();

        // Frame counter wrap
        force dut.r_frame_count = 16'hFFFF;
        tick();
        release dut.r_frame_count;
        check("wrap_preload", 32'(frame_count), 32'h0000_FFFF);
        cpu_wr(8'd35, 32'h0);
        vblank = 1'b1;
        xfer(0, 0, 32'h0);
        check("wrap_nwrites", 32'(x_nwr), 32'd36);
        check("wrap_count",   32'(frame_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
